instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle instruction sequencer for the miniMips core. It owns the program counter, fetches 9-bit instructions from instruction memory, and holds each instruction stable for the decoder. It steps each instruction through decode, execute, optional data-memory access and write-back, gating register-file writes so each instruction commits exactly once. It sits between instruction memory, the decoder, the ALU branch flag and the data-memory handshake.

## Interface
- PC_W, 10, program counter / instruction address width
- INSTR_W, 9, instruction width
- CNT_W, 16, cycle counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins execution at PC 0 (honoured in IDLE and DONE only)
- end_pc  in  PC_W  program terminates when next PC equals this value
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (= pc)
- imem_valid  in  1  imem_data valid this cycle
- imem_data  in  INSTR_W  fetched instruction
- instr  out  INSTR_W  latched instruction driven to the decoder
- mem_read  in  1  decoder: instruction reads data memory
- mem_write  in  1  decoder: instruction writes data memory
- dmem_req  out  1  data-memory access enable
- dmem_ack  in  1  data-memory access complete
- branch_taken  in  1  ALU branch resolution, sampled in EXEC
- branch_off  in  8  signed branch offset from register file, sampled in EXEC
- wb_en  out  1  register-file write strobe (ANDed with decoder write enables downstream)
- pc  out  PC_W  current program counter
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE
- cycle_count  out  CNT_W  cycles spent executing, saturating

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, DONE.
- IDLE: start -> pc=0, cycle_count=0, next FETCH; if end_pc==0, next DONE instead.
- FETCH: imem_req=1, imem_addr=pc. Hold until imem_valid; on imem_valid latch imem_data into instr, next DECODE. imem_valid outside FETCH is ignored.
- DECODE: one cycle, instr stable, no strobes; next EXEC.
- EXEC: one cycle. Register taken=branch_taken and off=branch_off. Next MEM if mem_read|mem_write, else WB.
- MEM: dmem_req=1 held until dmem_ack (an ack in the same cycle as the first req counts); next WB. dmem_ack outside MEM is ignored.
- WB: wb_en=1 for exactly one cycle. pc <= taken ? pc + sign_extend(off) : pc + 1, truncated modulo 2^PC_W. Next DONE if the new pc == end_pc, else FETCH.
- DONE: done=1, instr holds the last value; start -> same as start from IDLE.
- start in FETCH..WB is ignored. A program never branches into DONE except via the end_pc match.
- cycle_count increments in every FETCH/DECODE/EXEC/MEM/WB cycle and saturates at 2^CNT_W-1.

## Timing
- Reset (async assert, any state): state=IDLE; pc=0, instr=0, cycle_count=0; imem_req, dmem_req, wb_en, busy and done all 0. Outputs take reset values immediately. An in-flight fetch or memory access is abandoned with no write-back.
- All outputs are registered or decoded from the state register only. No combinational path from input to output.
- Minimum instruction latency is 4 cycles for a non-memory instruction (imem_valid in the first FETCH cycle) and 5 cycles with memory. Each extra wait cycle on imem_valid or dmem_ack adds 1.
- The instr change is visible the cycle after imem_valid. Decoder outputs are used from DECODE onward.
- The pc update is visible the cycle after WB. imem_addr for the next fetch equals that value.

## Test plan
- Reset mid-MEM with dmem_req high -> next observed cycle: all outputs 0, state IDLE; a later dmem_ack produces no wb_en.
- start, end_pc=3, three ALU instructions with imem_valid and dmem_ack immediate -> wb_en pulses at cycles 4, 8, 12 after start; done asserted at cycle 13; cycle_count=12.
- Load instruction (mem_read=1) with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, exactly one wb_en, instruction takes 8 cycles.
- Branch at pc=5 with branch_taken=1, branch_off=8'hFD -> next imem_addr=2. Branch at pc=1020 with off=+10 -> next imem_addr=6 (wrap).
- imem_valid withheld 5 cycles in FETCH; spurious imem_valid and start during EXEC -> imem_req held 6 cycles, instr unchanged by the spurious pulses, no restart.
- Saturation: force a long stall with CNT_W=4 -> cycle_count stops at 15. end_pc=0 with start -> done the next cycle, no fetch issued.

Source files
------------

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer for the miniMips core: owns the PC, fetches and
// holds instructions, and steps each through decode/execute/memory/write-back once.
module instr_sequencer #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 9,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [PC_W-1:0]    end_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    input  logic               mem_read,
    input  logic               mem_write,
    output logic               dmem_req,
    input  logic               dmem_ack,
    input  logic               branch_taken,
    input  logic [7:0]         branch_off,
    output logic               wb_en,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               taken_q, taken_d;
    logic [7:0]         off_q, off_d;

    logic [PC_W+7:0]    off_sext;
    logic [PC_W-1:0]    pc_next;
    logic               in_flight;

    // Offset is sign-extended past PC_W so any PC width truncates cleanly.
    assign off_sext  = {{PC_W{off_q[7]}}, off_q};
    assign pc_next   = taken_q ? (pc_q + off_sext[PC_W-1:0]) : (pc_q + PC_W'(1));
    assign in_flight = (state_q != S_IDLE) && (state_q != S_DONE);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        taken_d = taken_q;
        off_d   = off_q;

        if (in_flight && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    pc_d    = '0;
                    cnt_d   = '0;
                    state_d = (end_pc == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_valid) begin
                    instr_d = imem_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            // Branch resolution is captured here so WB does not depend on live inputs.
            S_EXEC: begin
                taken_d = branch_taken;
                off_d   = branch_off;
                state_d = (mem_read || mem_write) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (dmem_ack) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                pc_d    = pc_next;
                state_d = (pc_next == end_pc) ? S_DONE : S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            cnt_q   <= '0;
            taken_q <= 1'b0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            taken_q <= taken_d;
            off_q   <= off_d;
        end
    end

    // Strobes decode from the state register only, so no input reaches an output.
    assign imem_req    = (state_q == S_FETCH);
    assign dmem_req    = (state_q == S_MEM);
    assign wb_en       = (state_q == S_WB);
    assign busy        = in_flight;
    assign done        = (state_q == S_DONE);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a procedural program-level model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_instr_sequencer;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 9;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [PC_W-1:0]    end_pc = '0;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_valid = 1'b0;
    logic [INSTR_W-1:0] imem_data = '0;
    logic [INSTR_W-1:0] instr;
    logic               mem_read = 1'b0;
    logic               mem_write = 1'b0;
    logic               dmem_req;
    logic               dmem_ack = 1'b0;
    logic               branch_taken = 1'b0;
    logic [7:0]         branch_off = '0;
    logic               wb_en;
    logic [PC_W-1:0]    pc;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   cycle_count;

    instr_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .end_pc(end_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
        .imem_data(imem_data), .instr(instr), .mem_read(mem_read),
        .mem_write(mem_write), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .branch_taken(branch_taken), .branch_off(branch_off), .wb_en(wb_en),
        .pc(pc), .busy(busy), .done(done), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Program tables indexed by PC: instruction word, decoder flags, branch and ack delay.
    logic [INSTR_W-1:0] prog_mem [1024];
    bit                 is_load  [1024];
    bit                 is_store [1024];
    bit                 br_tk    [1024];
    logic [7:0]         br_off   [1024];
    int                 dly      [1024];

    int  imem_delay = 0;
    int  fwait = 0, dwait = 0;
    bit  pend_start = 0, pend_valid = 0, force_ack = 0;
    int  cyc = 0, n_wb = 0, n_dreq = 0, n_ireq = 0;
    int  wb_at[$];
    int  n_vec = 0, n_err = 0;
    bit  cmp_en = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [PC_W-1:0]    m_pc;
    logic [INSTR_W-1:0] m_instr;
    int                 m_cnt;
    bit                 m_ireq, m_dreq, m_wb, m_busy, m_done;

    task automatic m_clear();
        m_pc = '0; m_instr = '0; m_cnt = 0;
        m_ireq = 0; m_dreq = 0; m_wb = 0; m_busy = 0; m_done = 0;
    endtask

    task automatic m_set(input bit ireq, input bit dreq, input bit wb);
        m_ireq = ireq; m_dreq = dreq; m_wb = wb; m_busy = 1; m_done = 0;
    endtask

    task automatic m_tick(output bit ab);
        @(posedge clk or negedge rst_n);
        ab = (rst_n == 1'b0);
    endtask

    task automatic m_busy_cycle(output bit ab);
        m_tick(ab);
        if (ab) m_clear();
        else if (m_cnt < CNT_MAX) m_cnt++;
    endtask

    task automatic m_run();
        bit ab;
        bit tk;
        logic signed [7:0] off;
        bit use_mem;
        int nxt;
        m_pc = '0;
        m_cnt = 0;
        if (end_pc == '0) begin
            m_ireq = 0; m_dreq = 0; m_wb = 0; m_busy = 0; m_done = 1;
            return;
        end
        forever begin
            m_set(1, 0, 0);
            do begin
                m_busy_cycle(ab);
                if (ab) return;
            end while (imem_valid !== 1'b1);
            m_instr = imem_data;
            m_set(0, 0, 0);
            m_busy_cycle(ab);
            if (ab) return;
            m_busy_cycle(ab);
            if (ab) return;
            tk = branch_taken;
            off = branch_off;
            use_mem = mem_read | mem_write;
            if (use_mem) begin
                m_set(0, 1, 0);
                do begin
                    m_busy_cycle(ab);
                    if (ab) return;
                end while (dmem_ack !== 1'b1);
            end
            m_set(0, 0, 1);
            m_busy_cycle(ab);
            if (ab) return;
            nxt = tk ? (int'(m_pc) + int'(off)) : (int'(m_pc) + 1);
            m_pc = PC_W'(nxt);
            if (m_pc == end_pc) begin
                m_ireq = 0; m_dreq = 0; m_wb = 0; m_busy = 0; m_done = 1;
                return;
            end
        end
    endtask

    initial begin : model
        bit ab;
        m_clear();
        forever begin
            m_tick(ab);
            if (ab) m_clear();
            else if (start === 1'b1) m_run();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : compare
        forever begin
            @(posedge clk);
            #3;
            if (cmp_en) begin
                checkOutput("pc", pc, m_pc);
                checkOutput("imem_addr", imem_addr, m_pc);
                checkOutput("instr", instr, m_instr);
                checkOutput("cycle_count", cycle_count, m_cnt);
                checkOutput("imem_req", imem_req, m_ireq);
                checkOutput("dmem_req", dmem_req, m_dreq);
                checkOutput("wb_en", wb_en, m_wb);
                checkOutput("busy", busy, m_busy);
                checkOutput("done", done, m_done);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic clearTables();
        for (int i = 0; i < 1024; i++) begin
            is_load[i] = 0; is_store[i] = 0; br_tk[i] = 0; br_off[i] = '0; dly[i] = 0;
        end
        imem_delay = 0;
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        cyc++;
        if (wb_en) begin n_wb++; wb_at.push_back(cyc); end
        if (dmem_req) n_dreq++;
        if (imem_req) n_ireq++;
        if (imem_req) begin
            imem_valid = (fwait >= imem_delay);
            fwait = imem_valid ? 0 : fwait + 1;
        end else begin
            imem_valid = 1'b0;
            fwait = 0;
        end
        imem_data = prog_mem[imem_addr];
        if (pend_valid) begin
            imem_valid = 1'b1;
            imem_data = 9'h1AA;
        end
        if (dmem_req) begin
            dmem_ack = (dwait >= dly[imem_addr]);
            dwait = dmem_ack ? 0 : dwait + 1;
        end else begin
            dmem_ack = 1'b0;
            dwait = 0;
        end
        if (force_ack) dmem_ack = 1'b1;
        mem_read = is_load[imem_addr];
        mem_write = is_store[imem_addr];
        branch_taken = br_tk[imem_addr];
        branch_off = br_off[imem_addr];
        start = pend_start;
        pend_start = 0;
        pend_valid = 0;
    endtask

    task automatic kick();
        pend_start = 1;
        applyStimulus();
        cyc = 0; n_wb = 0; n_dreq = 0; n_ireq = 0;
        wb_at.delete();
    endtask

    initial begin : stimulus
        for (int i = 0; i < 1024; i++) prog_mem[i] = INSTR_W'(i * 37 + 5);
        clearTables();

        // Power-on reset
        #2;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_imem_req", imem_req, 0);
        checkOutput("rst_pc", pc, 0);
        #10 rst_n = 1'b1;
        cmp_en = 1;
        applyStimulus();

        // Three ALU instructions, immediate handshakes
        $display("[TB] three ALU instructions");
        end_pc = 10'd3;
        kick();
        for (int i = 1; i <= 13; i++) begin
            applyStimulus();
            checkOutput("t1_wb_en", wb_en, (i == 4 || i == 8 || i == 12) ? 1 : 0);
        end
        checkOutput("t1_done", done, 1);
        checkOutput("t1_cycle_count", cycle_count, 12);
        checkOutput("t1_pc", pc, 3);
        checkOutput("t1_model_pc", m_pc, 3);

        // Load with 3 ack wait cycles, then a store with immediate ack (restart from DONE)
        $display("[TB] load then store");
        clearTables();
        is_load[0] = 1; dly[0] = 3; is_store[1] = 1;
        end_pc = 10'd2;
        kick();
        for (int i = 1; i <= 14; i++) begin
            applyStimulus();
            if (i == 8) begin
                checkOutput("t2_load_dmem_cycles", n_dreq, 4);
                checkOutput("t2_load_wb_count", n_wb, 1);
            end
        end
        checkOutput("t2_wb_count", n_wb, 2);
        if (wb_at.size() == 2) begin
            checkOutput("t2_wb_cycle0", wb_at[0], 8);
            checkOutput("t2_wb_cycle1", wb_at[1], 13);
        end
        checkOutput("t2_done", done, 1);
        checkOutput("t2_cycle_count", cycle_count, 13);

        // Branch chain 0 -> 5 -> 2 -> 1020 -> 6 with wrap; count saturates
        $display("[TB] branch chain");
        clearTables();
        br_tk[0] = 1;    br_off[0] = 8'd5;
        br_tk[5] = 1;    br_off[5] = 8'hFD;
        br_tk[2] = 1;    br_off[2] = 8'hFA;
        br_tk[1020] = 1; br_off[1020] = 8'd10;
        end_pc = 10'd6;
        kick();
        for (int i = 1; i <= 17; i++) begin
            applyStimulus();
            if (i == 2)  checkOutput("t3_instr0", instr, prog_mem[0]);
            if (i == 5)  checkOutput("t3_addr_5", imem_addr, 5);
            if (i == 9)  checkOutput("t3_addr_2", imem_addr, 2);
            if (i == 9)  checkOutput("t3_model_addr_2", m_pc, 2);
            if (i == 13) checkOutput("t3_addr_1020", imem_addr, 1020);
            if (i == 16) checkOutput("t3_cnt_sat16", cycle_count, 15);
        end
        checkOutput("t3_addr_6", imem_addr, 6);
        checkOutput("t3_done", done, 1);
        checkOutput("t3_cnt_sat17", cycle_count, 15);

        // Fetch withheld 5 cycles; spurious imem_valid and start in EXEC
        $display("[TB] fetch stall and spurious pulses");
        clearTables();
        br_off[0] = 8'h40;
        imem_delay = 5;
        end_pc = 10'd1;
        kick();
        for (int i = 1; i <= 13; i++) begin
            if (i == 8) begin pend_valid = 1; pend_start = 1; end
            applyStimulus();
            if (i == 9) checkOutput("t4_instr_wb", instr, prog_mem[0]);
        end
        imem_delay = 0;
        checkOutput("t4_imem_req_cycles", n_ireq, 6);
        checkOutput("t4_wb_count", n_wb, 1);
        if (wb_at.size() == 1) checkOutput("t4_wb_cycle", wb_at[0], 9);
        checkOutput("t4_instr_hold", instr, prog_mem[0]);
        checkOutput("t4_done", done, 1);
        checkOutput("t4_pc", pc, 1);
        checkOutput("t4_cycle_count", cycle_count, 9);

        // Reset while a data access is outstanding
        $display("[TB] reset mid-MEM");
        clearTables();
        is_load[0] = 1; dly[0] = 20;
        end_pc = 10'd1;
        kick();
        for (int i = 1; i <= 6; i++) applyStimulus();
        checkOutput("t5_dmem_req_pre", dmem_req, 1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("t5_dmem_req", dmem_req, 0);
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_done", done, 0);
        checkOutput("t5_wb_en", wb_en, 0);
        checkOutput("t5_instr", instr, 0);
        checkOutput("t5_cnt", cycle_count, 0);
        applyStimulus();
        applyStimulus();
        #1 rst_n = 1'b1;
        force_ack = 1;
        n_wb = 0;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus();
            checkOutput("t5_idle_busy", busy, 0);
            checkOutput("t5_idle_done", done, 0);
        end
        force_ack = 0;
        checkOutput("t5_no_wb", n_wb, 0);

        // end_pc == 0: straight to DONE, no fetch
        $display("[TB] end_pc zero");
        end_pc = 10'd0;
        kick();
        applyStimulus();
        checkOutput("t6_done", done, 1);
        checkOutput("t6_busy", busy, 0);
        applyStimulus();
        applyStimulus();
        checkOutput("t6_no_fetch", n_ireq, 0);
        checkOutput("t6_pc", pc, 0);

        applyStimulus();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
